// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 max-pool packer: frame geometry, derived
// counter widths, the pixel type, the FSM state encoding and a signed max.
package pool_pkg;

  localparam int DATA_W  = 16;
  localparam int IN_W    = 28;
  localparam int IN_H    = 28;
  localparam int LANES   = 4;
  localparam int POOL_W  = IN_W / 2;
  localparam int POOL_H  = IN_H / 2;
  localparam int BUNDLES = POOL_W * POOL_H / LANES;

  localparam int COL_W  = $clog2(IN_W);
  localparam int ROW_W  = $clog2(IN_H);
  localparam int PIX_W  = $clog2(POOL_W);
  localparam int PACK_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef logic signed [DATA_W-1:0] pix_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Signed maximum; on a tie either operand is correct since they are equal.
  function automatic pix_t smax(input pix_t a, input pix_t b);
    pix_t m;
    if (a > b) begin
      m = a;
    end else begin
      m = b;
    end
    return m;
  endfunction

endpackage

// File: rtl/pool_max_packer_if.sv
// Stream-in / bundle-out bus of the max-pool packer. The producer side
// (conv stream source, pooled-buffer sink) uses master; the packer uses slave.
interface pool_max_packer_if;
  import pool_pkg::*;

  logic              start;
  logic              conv_valid;
  logic [DATA_W-1:0] conv_data;
  logic              pool_write_en;
  logic [DATA_W-1:0] pool_data0;
  logic [DATA_W-1:0] pool_data1;
  logic [DATA_W-1:0] pool_data2;
  logic [DATA_W-1:0] pool_data3;
  logic              pool_busy;
  logic              frame_done;

  modport master (
    output start, conv_valid, conv_data,
    input  pool_write_en, pool_data0, pool_data1, pool_data2, pool_data3,
           pool_busy, frame_done
  );

  modport slave (
    input  start, conv_valid, conv_data,
    output pool_write_en, pool_data0, pool_data1, pool_data2, pool_data3,
           pool_busy, frame_done
  );

endinterface

// File: rtl/pool_line_buf.sv
// One pooled-row line buffer: holds the horizontal maxima of an even conv row
// so the following odd row can finish each 2x2 window. Contents need no reset
// because every entry is written on the even row before the odd row reads it.
module pool_line_buf import pool_pkg::*; #(
  parameter int DEPTH = POOL_W,
  parameter int AW    = PIX_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pix_t          wdata,
  input  logic [AW-1:0] raddr,
  output pix_t          rdata
);

  pix_t mem [DEPTH];

  // Store the even-row horizontal max for its pooled column.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pool_max_packer.sv
// 2x2 signed max-pool over a raster conv stream, packing LANES pooled values
// into one write bundle. Optional macro POOL_RELU_EN clamps negative pooled
// values to zero before they enter a lane.
module pool_max_packer import pool_pkg::*; (
  input  logic               clk,
  input  logic               reset,
  pool_max_packer_if.slave   bus
);

  state_t            state_r;
  state_t            state_next_s;
  logic [COL_W-1:0]  col_r;
  logic [ROW_W-1:0]  row_r;
  logic [PACK_W-1:0] pack_r;
  pix_t              h_reg_r;
  pix_t              lane_r [LANES-1];
  pix_t              out_r  [LANES];
  logic              write_en_r;
  logic              done_r;
  logic              busy_r;

  logic              accept_s;
  logic              start_frame_s;
  logic              last_col_s;
  logic              last_pix_s;
  logic              lb_we_s;
  logic [PIX_W-1:0]  lb_addr_s;
  pix_t              hmax_s;
  pix_t              lb_rdata_s;
  pix_t              pmax_s;
  pix_t              pooled_s;

  assign accept_s      = (state_r == RUN) && bus.conv_valid;
  assign start_frame_s = (state_r == IDLE) && bus.start;
  assign last_col_s    = (col_r == COL_W'(IN_W - 1));
  assign last_pix_s    = last_col_s && (row_r == ROW_W'(IN_H - 1));
  assign lb_addr_s     = PIX_W'(col_r >> 1);
  assign hmax_s        = smax(h_reg_r, bus.conv_data);
  assign lb_we_s       = accept_s && col_r[0] && !row_r[0];
  assign pmax_s        = smax(lb_rdata_s, hmax_s);

`ifdef POOL_RELU_EN
  assign pooled_s = pmax_s[DATA_W-1] ? pix_t'('0) : pmax_s;
`else
  assign pooled_s = pmax_s;
`endif

  pool_line_buf u_line_buf (
    .clk   (clk),
    .we    (lb_we_s),
    .waddr (lb_addr_s),
    .wdata (hmax_s),
    .raddr (lb_addr_s),
    .rdata (lb_rdata_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state: frame starts on start, ends on the last accepted pixel, then one flush cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (accept_s && last_pix_s) begin
          state_next_s = FLUSH;
        end else begin
          state_next_s = RUN;
        end
      end
      FLUSH:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Raster counters, horizontal latch, lane packing and registered bundle outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_r      <= '0;
      row_r      <= '0;
      pack_r     <= '0;
      h_reg_r    <= '0;
      write_en_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      for (int i = 0; i < LANES - 1; i++) lane_r[i] <= '0;
      for (int i = 0; i < LANES; i++)     out_r[i]  <= '0;
    end else begin
      write_en_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= (state_next_s != IDLE);
      if (start_frame_s) begin
        col_r  <= '0;
        row_r  <= '0;
        pack_r <= '0;
      end else if (accept_s) begin
        if (last_col_s) begin
          col_r <= '0;
          if (row_r == ROW_W'(IN_H - 1)) begin
            row_r <= '0;
          end else begin
            row_r <= row_r + ROW_W'(1);
          end
        end else begin
          col_r <= col_r + COL_W'(1);
        end
        if (!col_r[0]) begin
          h_reg_r <= bus.conv_data;
        end else if (row_r[0]) begin
          if (pack_r == PACK_W'(LANES - 1)) begin
            // Bundle complete: earlier lanes plus this value go out together.
            pack_r <= '0;
            for (int i = 0; i < LANES - 1; i++) out_r[i] <= lane_r[i];
            out_r[LANES-1] <= pooled_s;
            write_en_r     <= 1'b1;
            done_r         <= last_pix_s;
          end else begin
            lane_r[pack_r] <= pooled_s;
            pack_r         <= pack_r + PACK_W'(1);
          end
        end
      end
    end
  end

  assign bus.pool_write_en = write_en_r;
  assign bus.pool_data0    = out_r[0];
  assign bus.pool_data1    = out_r[1];
  assign bus.pool_data2    = out_r[2];
  assign bus.pool_data3    = out_r[3];
  assign bus.pool_busy     = busy_r;
  assign bus.frame_done    = done_r;

endmodule
